// File: rtl/div_seq_if.sv
// Execute-to-divider request/result bundle; execute is master, divider is slave.
interface div_seq_if;
   logic        go;
   logic        kill;
   logic        is_signed;
   logic        want_rem;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;

   modport master (
      output go, kill, is_signed, want_rem, dividend, divisor,
      input  busy, done, result
   );

   modport slave (
      input  go, kill, is_signed, want_rem, dividend, divisor,
      output busy, done, result
   );
endinterface

// File: rtl/div_seq.sv
// Iterative RV32M divide sequencer: done at accept+32/BITS_PER_CYCLE+2, or accept+1 on cache hit/div0/overflow.
// Execute holds go until done; kill aborts any state; operands are latched at accept so they may change while busy.
module div_seq #(
   parameter int BITS_PER_CYCLE = 1
) (
   input logic     clk_core,
   input logic     reset_n,
   div_seq_if.slave bus
);

   localparam int         ITERS   = 32 / BITS_PER_CYCLE;
   localparam logic [5:0] ITERS_C = 6'(ITERS);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic        busy_q;
   logic [31:0] res;

   logic        op_sgn;
   logic        op_rem;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        neg_q;
   logic        neg_r;
   logic [31:0] div_b;
   logic [32:0] pr;
   logic [31:0] quo;

   logic        c_vld;
   logic        c_sgn;
   logic [31:0] c_a;
   logic [31:0] c_b;
   logic [31:0] c_q;
   logic [31:0] c_r;

   logic        sgn_a;
   logic        sgn_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic        hit;
   logic        dz;
   logic        ovf;
   logic [32:0] pr_n;
   logic [31:0] quo_n;
   logic [31:0] q_fin;
   logic [31:0] r_fin;

   assign sgn_a = bus.is_signed & bus.dividend[31];
   assign sgn_b = bus.is_signed & bus.divisor[31];
   assign abs_a = sgn_a ? -bus.dividend : bus.dividend;
   assign abs_b = sgn_b ? -bus.divisor  : bus.divisor;

   assign hit = c_vld & (c_a == bus.dividend) & (c_b == bus.divisor) & (c_sgn == bus.is_signed);
   assign dz  = (bus.divisor == 32'h0);
   assign ovf = bus.is_signed & (bus.dividend == 32'h8000_0000) & (bus.divisor == 32'hFFFF_FFFF);

   // Restoring steps: shift one dividend bit into the partial remainder, keep the
   // difference unless it borrowed; the quotient bit is the inverted borrow.
   always_comb begin : step
      logic [33:0] sh;
      logic [33:0] diff;
      pr_n  = pr;
      quo_n = quo;
      sh    = 34'h0;
      diff  = 34'h0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         sh    = {pr_n, quo_n[31]};
         diff  = sh - {2'b00, div_b};
         pr_n  = diff[33] ? sh[32:0] : diff[32:0];
         quo_n = {quo_n[30:0], ~diff[33]};
      end
   end

   assign q_fin = neg_q ? -quo       : quo;
   assign r_fin = neg_r ? -pr[31:0]  : pr[31:0];

   always_ff @(posedge clk_core) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         busy_q <= 1'b0;
         res    <= 32'h0;
         op_sgn <= 1'b0;
         op_rem <= 1'b0;
         op_a   <= 32'h0;
         op_b   <= 32'h0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div_b  <= 32'h0;
         pr     <= 33'h0;
         quo    <= 32'h0;
         c_vld  <= 1'b0;
         c_sgn  <= 1'b0;
         c_a    <= 32'h0;
         c_b    <= 32'h0;
         c_q    <= 32'h0;
         c_r    <= 32'h0;
      end else if (bus.kill) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.go) begin
                  op_sgn <= bus.is_signed;
                  op_rem <= bus.want_rem;
                  op_a   <= bus.dividend;
                  op_b   <= bus.divisor;
                  neg_q  <= sgn_a ^ sgn_b;
                  neg_r  <= sgn_a;
                  if (hit) begin
                     res   <= bus.want_rem ? c_r : c_q;
                     state <= DONE;
                  end else if (dz) begin
                     res   <= bus.want_rem ? bus.dividend : 32'hFFFF_FFFF;
                     state <= DONE;
                  end else if (ovf) begin
                     res   <= bus.want_rem ? 32'h0 : 32'h8000_0000;
                     state <= DONE;
                  end else begin
                     pr     <= 33'h0;
                     quo    <= abs_a;
                     div_b  <= abs_b;
                     cnt    <= ITERS_C;
                     busy_q <= 1'b1;
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               pr  <= pr_n;
               quo <= quo_n;
               cnt <= cnt - 6'd1;
               if (cnt == 6'd1) begin
                  state <= FIX;
               end
            end
            FIX: begin
               res    <= op_rem ? r_fin : q_fin;
               c_vld  <= 1'b1;
               c_sgn  <= op_sgn;
               c_a    <= op_a;
               c_b    <= op_b;
               c_q    <= q_fin;
               c_r    <= r_fin;
               busy_q <= 1'b0;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = (state == DONE) & ~bus.kill;
   assign bus.result = res;

endmodule
